spi_rx_reg_writer: RTL

Consumes the framed byte stream produced by the queued SPI slave receiver (header byte 0x99, then payload, last byte flagged by `rxe`) and turns it into 32-bit register write strobes for the motor-controller register file. It sits directly downstream of the SPI receive queue and upstream of the register bank. Malformed frames are discarded and counted. Good frames are counted too.

---
 rtl/spi_rx_reg_writer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_rx_reg_writer.sv
// Turns header-framed SPI receive bytes into 32-bit register write strobes.
// Good and malformed frames are counted with saturating counters.
module spi_rx_reg_writer (
   input  logic        c,
   input  logic        rst,
   input  logic [7:0]  rxd,
   input  logic        rxdv,
   input  logic        rxe,
   output logic [7:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        wr_en,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   localparam logic [7:0] HEADER    = 8'h99;
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_NOP   = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_NOP,
      ST_DISCARD
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  addr_reg;
   logic [23:0] word_reg;
   logic [1:0]  idx;
   logic        word_fire;
   logic        accept;
   logic        reject;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge c or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (rxdv) begin
         case (state)
            ST_IDLE:  state_nxt = (rxd == HEADER) ? ST_CMD : ST_DISCARD;
            ST_CMD: begin
               if (rxd == CMD_WRITE)    state_nxt = ST_ADDR;
               else if (rxd == CMD_NOP) state_nxt = ST_NOP;
               else                     state_nxt = ST_DISCARD;
            end
            ST_ADDR:    state_nxt = ST_DATA;
            ST_DATA:    state_nxt = ST_DATA;
            ST_NOP:     state_nxt = ST_NOP;
            default:    state_nxt = ST_DISCARD;
         endcase
         // Frame end overrides whatever this byte would otherwise have selected.
         if (rxe) state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      word_fire = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      if (rxdv) begin
         if (state == ST_DATA && idx == 2'd3) word_fire = 1'b1;
         if (rxe) begin
            case (state)
               ST_IDLE: reject = 1'b1;
               ST_CMD: begin
                  if (rxd == CMD_NOP) accept = 1'b1;
                  else                reject = 1'b1;
               end
               ST_ADDR: accept = 1'b1;
               ST_DATA: begin
                  // Only a whole number of words is a good frame.
                  if (idx == 2'd3) accept = 1'b1;
                  else             reject = 1'b1;
               end
               ST_NOP:  accept = 1'b1;
               default: reject = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         addr_reg   <= '0;
         word_reg   <= '0;
         idx        <= '0;
      end else begin
         wr_en      <= word_fire;
         frame_done <= accept;
         frame_err  <= reject;
         if (accept) good_cnt <= sat_inc(good_cnt);
         if (reject) bad_cnt  <= sat_inc(bad_cnt);
         if (rxdv && state == ST_ADDR) begin
            addr_reg <= rxd;
            idx      <= 2'd0;
         end
         // Little-endian assembly: earlier bytes shift toward bit 0.
         if (rxdv && state == ST_DATA) begin
            idx      <= idx + 2'd1;
            word_reg <= {rxd, word_reg[23:8]};
         end
         if (word_fire) begin
            wr_addr  <= addr_reg;
            wr_data  <= {rxd, word_reg};
            addr_reg <= addr_reg + 8'd1;
         end
      end
   end

endmodule
